// File: rtl/demux13x8_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux13x8_buf_if
// Brief    : Producer stream and three consumer-port handshakes of the 1:3 demux
// Revision : 1.0
// ============================================================================
interface demux13x8_buf_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] datain;
  logic [1:0]       s;

  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic [WIDTH-1:0] dataout_a;
  logic [WIDTH-1:0] dataout_b;
  logic [WIDTH-1:0] dataout_c;

  modport master (
    output in_valid, datain, s, a_ready, b_ready, c_ready,
    input  in_ready, a_valid, b_valid, c_valid, dataout_a, dataout_b, dataout_c
  );

  modport slave (
    input  in_valid, datain, s, a_ready, b_ready, c_ready,
    output in_ready, a_valid, b_valid, c_valid, dataout_a, dataout_b, dataout_c
  );
endinterface
`default_nettype wire

// File: rtl/demux13x8_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux13x8_buf
// Brief    : Registered 1:3 word demux, one holding register per port,
//            per-port delivered-word counters and sticky illegal-select flag
// Revision : 1.0
// ============================================================================
module demux13x8_buf #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  demux13x8_buf_if.slave     bus,
  input  wire logic          clr_err,
  output logic [CW-1:0]      count_a,
  output logic [CW-1:0]      count_b,
  output logic [CW-1:0]      count_c,
  output logic               err
);

  localparam logic [1:0]    c_sel_illegal = 2'b11;
  localparam logic [CW-1:0] c_cnt_one     = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]       w_out_ready;
  logic [2:0]       w_valid;
  logic [WIDTH-1:0] w_data  [3];
  logic [CW-1:0]    w_count [3];
  logic             w_in_ready;
  logic             w_xfer;
  logic             r_err;

  assign w_out_ready = {bus.c_ready, bus.b_ready, bus.a_ready};

  // Only the selected port's occupancy gates the input; s=11 is always sunk.
  always_comb begin
    w_in_ready = 1'b1;
    case (bus.s)
      2'b00:   w_in_ready = !w_valid[0] || w_out_ready[0];
      2'b01:   w_in_ready = !w_valid[1] || w_out_ready[1];
      2'b10:   w_in_ready = !w_valid[2] || w_out_ready[2];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign w_xfer       = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_port
      localparam logic [1:0] c_sel = 2'(i);

      logic             w_load;
      logic             w_drain;
      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic [CW-1:0]    r_count;

      assign w_load  = w_xfer && (bus.s == c_sel);
      assign w_drain = r_valid && w_out_ready[i];

      // A load takes priority over a drain so a full port streams 1 word/cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_count <= '0;
        end else begin
          if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= bus.datain;
          end else if (w_drain) begin
            r_valid <= 1'b0;
          end
          if (w_drain) begin
            r_count <= r_count + c_cnt_one;
          end
        end
      end

      assign w_valid[i] = r_valid;
      assign w_data[i]  = r_data;
      assign w_count[i] = r_count;
    end
  endgenerate

  // Setting by an illegal transfer wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_xfer && (bus.s == c_sel_illegal)) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  assign bus.a_valid   = w_valid[0];
  assign bus.b_valid   = w_valid[1];
  assign bus.c_valid   = w_valid[2];
  assign bus.dataout_a = w_data[0];
  assign bus.dataout_b = w_data[1];
  assign bus.dataout_c = w_data[2];
  assign count_a       = w_count[0];
  assign count_b       = w_count[1];
  assign count_c       = w_count[2];
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_demux13x8_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux13x8_buf
// Brief    : Directed plus randomized bench for demux13x8_buf with a port-level model
// Revision : 1.0
// ============================================================================
module tb_demux13x8_buf;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] count_a;
  logic [7:0] count_b;
  logic [7:0] count_c;
  logic       err;

  demux13x8_buf_if #(.WIDTH(8)) bus ();

  demux13x8_buf #(.WIDTH(8), .CW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .clr_err (clr_err),
    .count_a (count_a),
    .count_b (count_b),
    .count_c (count_c),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: each port is "occupied or not" plus the word it holds and a delivery tally.
  bit         m_full [3];
  logic [7:0] m_data [3];
  int         m_cnt  [3];
  bit         m_err;
  bit         last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit port_ready(input int p);
    case (p)
      0:       return bus.a_ready;
      1:       return bus.b_ready;
      default: return bus.c_ready;
    endcase
  endfunction

  function automatic bit exp_in_ready();
    int p;
    p = int'(bus.s);
    if (p == 3) return 1'b1;
    return !m_full[p] || port_ready(p);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_full[p] = 1'b0;
      m_data[p] = 8'h00;
      m_cnt[p]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a_valid"},   32'(bus.a_valid),   32'(m_full[0]));
    check({tag, ".b_valid"},   32'(bus.b_valid),   32'(m_full[1]));
    check({tag, ".c_valid"},   32'(bus.c_valid),   32'(m_full[2]));
    check({tag, ".dataout_a"}, 32'(bus.dataout_a), 32'(m_data[0]));
    check({tag, ".dataout_b"}, 32'(bus.dataout_b), 32'(m_data[1]));
    check({tag, ".dataout_c"}, 32'(bus.dataout_c), 32'(m_data[2]));
    check({tag, ".count_a"},   32'(count_a),       32'(m_cnt[0]));
    check({tag, ".count_b"},   32'(count_b),       32'(m_cnt[1]));
    check({tag, ".count_c"},   32'(count_c),       32'(m_cnt[2]));
    check({tag, ".err"},       32'(err),           32'(m_err));
  endtask

  // Inputs are already applied; check in_ready, clock once, advance model, check outputs.
  task automatic step(input string tag);
    bit rdy;
    bit xfer;
    int sel;
    #1;
    rdy = exp_in_ready();
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    xfer       = bus.in_valid && rdy;
    sel        = int'(bus.s);
    last_stall = bus.in_valid && !rdy;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int p = 0; p < 3; p++) begin
        bit drain;
        drain = m_full[p] && port_ready(p);
        if (xfer && sel == p) begin
          m_full[p] = 1'b1;
          m_data[p] = bus.datain;
        end else if (drain) begin
          m_full[p] = 1'b0;
        end
        if (drain) m_cnt[p] = (m_cnt[p] + 1) % 256;
      end
      if (xfer && sel == 3) m_err = 1'b1;
      else if (clr_err)     m_err = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] d);
    bus.in_valid = v;
    bus.s        = sel;
    bus.datain   = d;
  endtask

  initial begin
    int cnt_before;
    bus.in_valid = 1'b0;
    bus.s        = 2'b00;
    bus.datain   = 8'h00;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.c_ready  = 1'b0;
    last_stall   = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // Basic route to a
    bus.a_ready = 1'b1;
    drive(1'b1, 2'b00, 8'h3C);
    step("basic_load");
    check("basic_dataout_a", 32'(bus.dataout_a), 32'h3C);
    drive(1'b0, 2'b00, 8'h00);
    step("basic_drain");
    check("basic_count_a", 32'(count_a), 32'd1);

    // Back-pressure on b; c keeps flowing
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    drive(1'b1, 2'b01, 8'h11);
    step("bp_first");
    drive(1'b1, 2'b01, 8'h22);
    step("bp_stall");
    check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_hold_b", 32'(bus.dataout_b), 32'h11);
    drive(1'b1, 2'b10, 8'h22);
    step("bp_to_c");
    check("bp_dataout_c", 32'(bus.dataout_c), 32'h22);
    drive(1'b0, 2'b00, 8'h00);
    bus.b_ready = 1'b1;
    step("bp_drain_b");
    check("bp_count_c_zero", 32'(count_c), 32'd0);
    bus.c_ready = 1'b1;
    step("bp_drain_c");

    // Streaming on c
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 2'b10, 8'(k));
      step("stream");
      check("stream_word", 32'(bus.dataout_c), 32'(k));
    end
    drive(1'b0, 2'b00, 8'h00);
    step("stream_tail");
    check("stream_count_c", 32'(count_c), 32'd6);

    // Illegal select
    drive(1'b1, 2'b11, 8'hFF);
    step("illegal");
    check("illegal_err", 32'(err), 32'd1);
    drive(1'b0, 2'b00, 8'h00);
    clr_err = 1'b1;
    step("clr_alone");
    check("clr_err_zero", 32'(err), 32'd0);
    drive(1'b1, 2'b11, 8'h77);
    step("clr_vs_set");
    check("set_wins", 32'(err), 32'd1);
    clr_err = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    step("illegal_idle");

    // Counter wrap on a: 256 deliveries return count_a to its starting value
    cnt_before  = m_cnt[0];
    bus.a_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'b00, 8'($urandom));
      step("wrap");
    end
    drive(1'b0, 2'b00, 8'h00);
    step("wrap_tail");
    check("wrap_count_a", 32'(count_a), 32'(cnt_before));

    // Randomized traffic honouring the hold-while-stalled rule
    for (int k = 0; k < 400; k++) begin
      if (!last_stall) begin
        bus.in_valid = 1'($urandom_range(0, 3) != 0);
        bus.s        = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
        bus.datain   = 8'($urandom);
      end
      bus.a_ready = 1'($urandom);
      bus.b_ready = 1'($urandom);
      bus.c_ready = 1'($urandom);
      clr_err     = 1'($urandom_range(0, 7) == 0);
      step("random");
    end
    clr_err = 1'b0;

    // Async reset mid-stream: a holds 8'h5A with count_a=7
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    step("prep_reset");
    rst_n = 1'b1;
    bus.a_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 2'b00, 8'(k));
      step("prep_fill");
    end
    drive(1'b1, 2'b00, 8'h5A);
    step("prep_5a");
    bus.a_ready = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    step("prep_hold");
    check("prep_count_a", 32'(count_a), 32'd7);
    check("prep_dataout_a", 32'(bus.dataout_a), 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("in_reset_edge");
    rst_n       = 1'b1;
    bus.a_ready = 1'b1;
    drive(1'b1, 2'b00, 8'hA5);
    step("post_reset");
    check("post_reset_a", 32'(bus.dataout_a), 32'hA5);
    drive(1'b0, 2'b00, 8'h00);
    step("post_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
